// File: rtl/muxf8_rr_sched.sv
// Round-robin scheduler sharing one wide mux tree between NREQ requesters.
// A grant is held for a whole packet (until a LAST beat transfers), and the
// registered binary select drives the mux tree S inputs directly. A watchdog
// releases a grant whose owner stops presenting beats.
//
// Handshake: a beat transfers in a cycle where O_VLD and O_RDY are both high.
// O_VLD is REQ of the granted requester. O_RDY may be high without O_VLD, and
// O_VLD may be high without O_RDY. Only a transfer with O_LAST=1 ends the
// packet.
module muxf8_rr_sched #(
   parameter int NREQ  = 8,
   parameter int SEL_W = $clog2(NREQ),
   parameter int TMO   = 16
) (
   input  logic             CLK,
   input  logic             RESETN,
   input  logic [NREQ-1:0]  REQ,
   input  logic [NREQ-1:0]  LAST,
   input  logic             O_RDY,
   output logic [NREQ-1:0]  GNT,
   output logic [SEL_W-1:0] SEL,
   output logic             O_VLD,
   output logic             O_LAST,
   output logic             TMO_ERR,
   output logic             DBG_STATE
);

   localparam int WD_W = $clog2(TMO + 1);

   typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

   // Registers carry declaration initialisers so 2-state and 4-state runs match.
   state_t            state   = IDLE;
   logic [NREQ-1:0]   gnt_q   = '0;
   logic [SEL_W-1:0]  sel_q   = '0;
   logic [SEL_W-1:0]  ptr_q   = SEL_W'(NREQ - 1);
   logic [WD_W-1:0]   wdog_q  = '0;
   logic              tmo_q   = 1'b0;

   state_t            state_nxt;
   logic [NREQ-1:0]   gnt_nxt;
   logic [SEL_W-1:0]  sel_nxt;
   logic [SEL_W-1:0]  ptr_nxt;
   logic [WD_W-1:0]   wdog_nxt;
   logic              tmo_nxt;

   logic              found;
   logic [SEL_W-1:0]  win;
   logic [SEL_W-1:0]  cand;
   logic              cur_req;
   logic              cur_last;

   // GNT is zero outside LOCK, so masking with it gives the locked-only values.
   assign cur_req   = |(REQ & gnt_q);
   assign cur_last  = |(LAST & gnt_q);
   assign O_VLD     = cur_req;
   assign O_LAST    = cur_last;
   assign GNT       = gnt_q;
   assign SEL       = sel_q;
   assign TMO_ERR   = tmo_q;
   assign DBG_STATE = state;

   // Round-robin search starting just after the pointer; scanning from the far
   // end downwards lets the nearest requester overwrite earlier hits.
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int i = NREQ; i >= 1; i--) begin
         cand = SEL_W'((int'(ptr_q) + i) % NREQ);
         if (REQ[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   // Next-state logic: grant in IDLE, hold/release and watchdog in LOCK.
   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt_q;
      sel_nxt   = sel_q;
      ptr_nxt   = ptr_q;
      wdog_nxt  = wdog_q;
      tmo_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (found) begin
               state_nxt = LOCK;
               gnt_nxt   = NREQ'(1) << win;
               sel_nxt   = win;
               ptr_nxt   = win;
               wdog_nxt  = '0;
            end
         end
         LOCK: begin
            if (cur_req) begin
               // Any beat presented, accepted or back-pressured, keeps the owner alive.
               wdog_nxt = '0;
               if (O_RDY && cur_last) begin
                  state_nxt = IDLE;
                  gnt_nxt   = '0;
               end
            end else if (wdog_q == WD_W'(TMO - 1)) begin
               state_nxt = IDLE;
               gnt_nxt   = '0;
               tmo_nxt   = 1'b1;
               wdog_nxt  = '0;
            end else if (wdog_q != WD_W'(TMO)) begin
               wdog_nxt = wdog_q + WD_W'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
         end
      endcase
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         state  <= IDLE;
         gnt_q  <= '0;
         sel_q  <= '0;
         ptr_q  <= SEL_W'(NREQ - 1);
         wdog_q <= '0;
         tmo_q  <= 1'b0;
      end else begin
         state  <= state_nxt;
         gnt_q  <= gnt_nxt;
         sel_q  <= sel_nxt;
         ptr_q  <= ptr_nxt;
         wdog_q <= wdog_nxt;
         tmo_q  <= tmo_nxt;
      end
   end

endmodule

// File: tb/tb_muxf8_rr_sched.sv
// Directed bench for muxf8_rr_sched: a driver issues packets and pushes the
// expected {SEL, O_LAST} of every beat transfer; a monitor pops and compares
// on each accepted beat. Grant/release/watchdog timing is checked directly.
module tb_muxf8_rr_sched;

   localparam int NREQ  = 8;
   localparam int SEL_W = 3;
   localparam int W     = SEL_W + 1;

   logic             clk = 1'b0;
   logic             resetn = 1'b0;
   logic [NREQ-1:0]  req = '0;
   logic [NREQ-1:0]  last = '0;
   logic             o_rdy = 1'b0;
   logic [NREQ-1:0]  gnt;
   logic [SEL_W-1:0] sel;
   logic             o_vld;
   logic             o_last;
   logic             tmo_err;
   logic             dbg_state;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];
   int gcnt[NREQ];

   muxf8_rr_sched #(.NREQ(NREQ), .SEL_W(SEL_W), .TMO(16)) dut (
      .CLK(clk), .RESETN(resetn), .REQ(req), .LAST(last), .O_RDY(o_rdy),
      .GNT(gnt), .SEL(sel), .O_VLD(o_vld), .O_LAST(o_last),
      .TMO_ERR(tmo_err), .DBG_STATE(dbg_state)
   );

   // Clock
   always #5 clk = ~clk;

   // Global time limit
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "time limit reached");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int s, input bit l);
      exp_q.push_back({SEL_W'(s), l});
   endtask

   // Monitor: compare every accepted beat against the scoreboard queue.
   always @(negedge clk) begin
      if (resetn && o_vld && o_rdy) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL xfer_unexpected: got sel=%0d last=%0b expected no transfer at %0t",
                     sel, o_last, $time);
         end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            if ({sel, o_last} !== e) begin
               errors++;
               $display("FAIL xfer: got sel=%0d last=%0b expected sel=%0d last=%0b at %0t",
                        sel, o_last, e[W-1:1], e[0], $time);
            end
         end
      end
   end

   initial begin
      int bad;
      // Reset
      resetn = 1'b0;
      tick();
      tick();
      check("rst_gnt", 32'(gnt), 0);
      check("rst_sel", 32'(sel), 0);
      check("rst_tmo", 32'(tmo_err), 0);
      check("rst_state", 32'(dbg_state), 0);

      // Two requesters, single-beat packets: 0 first, then 7 after a bubble
      resetn = 1'b1;
      req = 8'h81; last = 8'hFF; o_rdy = 1'b1;
      push(0, 1'b1);
      push(7, 1'b1);
      #1;
      check("idle_vld", 32'(o_vld), 0);
      tick();
      check("t1_gnt0", 32'(gnt), 32'h01);
      check("t1_sel0", 32'(sel), 0);
      check("t1_lock", 32'(dbg_state), 1);
      tick();
      check("t1_bubble", 32'(gnt), 0);
      check("t1_idle", 32'(dbg_state), 0);
      req = 8'h80;
      tick();
      check("t1_gnt7", 32'(gnt), 32'h80);
      check("t1_sel7", 32'(sel), 7);
      tick();
      check("t1_rel7", 32'(gnt), 0);
      req = '0;
      tick();

      // All requesters, single-beat packets, 16 grants
      for (int i = 0; i < NREQ; i++) gcnt[i] = 0;
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < NREQ; i++) push(i, 1'b1);
      req = 8'hFF; last = 8'hFF; o_rdy = 1'b1;
      for (int c = 0; c < 32; c++) begin
         tick();
         for (int i = 0; i < NREQ; i++) if (gnt[i]) gcnt[i]++;
      end
      req = '0;
      for (int i = 0; i < NREQ; i++) check($sformatf("rr_cnt%0d", i), 32'(gcnt[i]), 2);

      // Requester 3 sends 4 beats while requester 5 waits
      req = 8'h28; last = 8'h00; o_rdy = 1'b1;
      push(3, 1'b0); push(3, 1'b0); push(3, 1'b0); push(3, 1'b1); push(5, 1'b1);
      for (int b = 0; b < 4; b++) begin
         tick();
         check($sformatf("pkt_hold%0d", b), 32'(gnt), 32'h08);
         if (b == 3) last = 8'h28;
      end
      tick();
      check("pkt_rel", 32'(gnt), 0);
      req = 8'h20;
      tick();
      check("pkt_next", 32'(gnt), 32'h20);
      check("pkt_next_sel", 32'(sel), 5);
      tick();
      req = '0;

      // Requester 2 under long backpressure: no watchdog
      req = 8'h04; last = 8'h00; o_rdy = 1'b0;
      tick();
      check("bp_gnt", 32'(gnt), 32'h04);
      bad = 0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (tmo_err !== 1'b0 || gnt !== 8'h04) bad++;
      end
      check("bp_hold", 32'(bad), 0);
      push(2, 1'b1);
      last = 8'h04; o_rdy = 1'b1;
      tick();
      check("bp_rel", 32'(gnt), 0);
      check("bp_no_tmo", 32'(tmo_err), 0);
      req = '0;

      // Requester 6 stalls: watchdog fires 16 cycles after the drop
      req = 8'h40; last = 8'h00; o_rdy = 1'b1;
      push(6, 1'b0);
      tick();
      check("wd_gnt", 32'(gnt), 32'h40);
      tick();
      req = '0;
      bad = 0;
      for (int k = 1; k <= 15; k++) begin
         tick();
         if (tmo_err !== 1'b0 || gnt !== 8'h40) bad++;
      end
      check("wd_early", 32'(bad), 0);
      tick();
      check("wd_pulse", 32'(tmo_err), 1);
      check("wd_rel", 32'(gnt), 0);
      check("wd_idle", 32'(dbg_state), 0);
      req = 8'h81; last = 8'hFF;
      push(7, 1'b1);
      tick();
      check("wd_pulse_end", 32'(tmo_err), 0);
      check("wd_next_gnt", 32'(gnt), 32'h80);
      check("wd_next_sel", 32'(sel), 7);
      tick();
      check("wd_next_rel", 32'(gnt), 0);
      req = '0;

      // Reset mid-packet on requester 4
      req = 8'h10; last = 8'h00; o_rdy = 1'b0;
      tick();
      check("mr_gnt", 32'(gnt), 32'h10);
      check("mr_sel", 32'(sel), 4);
      resetn = 1'b0;
      tick();
      check("mr_rst_gnt", 32'(gnt), 0);
      check("mr_rst_sel", 32'(sel), 0);
      check("mr_rst_tmo", 32'(tmo_err), 0);
      resetn = 1'b1;
      req = 8'h11; last = 8'hFF;
      tick();
      check("mr_next_gnt", 32'(gnt), 32'h01);
      check("mr_next_sel", 32'(sel), 0);
      push(0, 1'b1);
      o_rdy = 1'b1;
      tick();
      check("mr_next_rel", 32'(gnt), 0);
      req = '0;
      tick();
      tick();

      check("queue_drained", 32'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
